// File: rtl/fifo_readout_pkg.sv
// Shared types and defaults for the measurement-FIFO to UART readout scheduler.
package fifo_readout_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_SEND,
    S_NEXT,
    S_HDR
  } state_t;

  localparam int unsigned DEFAULT_DATA_W = 24;
  localparam int unsigned BYTES_PER_WORD = DEFAULT_DATA_W / 8;
  localparam logic [7:0]  DEFAULT_HDR_BYTE = 8'hA5;

endpackage

// File: rtl/word_byte_sel.sv
// Combinational pick of one byte from the latched word; index 0 is the MSB.
module word_byte_sel
  import fifo_readout_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        idx,
  output logic [7:0]        byte_out
);

  localparam int unsigned NBYTES = DATA_W / 8;

  always_comb begin
    byte_out = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (32'(idx) == i) byte_out = word[8*(NBYTES-1-i) +: 8];
    end
  end

endmodule

// File: rtl/fifo_readout_scheduler.sv
// Pops FIFO words and streams them MSB-first as bytes over a valid/ready link.
// Optional frame sync header: define FRAME_HEADER_EN.
module fifo_readout_scheduler
  import fifo_readout_pkg::*;
#(
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned USEDW_W     = 13,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned FRAME_WORDS = 16,
  parameter logic [7:0]  HDR_BYTE    = DEFAULT_HDR_BYTE
) (
  input  logic               tx_spi_sclk_wire,
  input  logic               rst,
  input  logic               enable,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic [DATA_W-1:0]  fifo_q,
  output logic               fifo_rdreq,
  output logic               uart_valid,
  input  logic               uart_ready,
  output logic [7:0]         uart_byte,
  output logic [1:0]         uart_counter,
  output logic               busy,
  output logic [11:0]        words_sent
);

  localparam int unsigned NBYTES   = DATA_W / 8;
  localparam logic [1:0]  LAST_IDX = 2'(NBYTES - 1);
  localparam logic [1:0]  LAT_LAST = 2'(RD_LATENCY - 1);

  if (RD_LATENCY < 1 || RD_LATENCY > 3 || (DATA_W % 8) != 0 || DATA_W > 32 ||
      FRAME_WORDS < 1) begin : g_bad_cfg
    $error("fifo_readout_scheduler: unsupported parameter set");
  end

  state_t            state, next_state;
  logic [1:0]        byte_idx;
  logic [1:0]        lat_cnt;
  logic [DATA_W-1:0] word;
  logic [11:0]       sent;
  logic [7:0]        sel_byte;
  logic              have_data;
  logic              xfer;
  logic              word_done;
  logic              hdr_due;

  assign have_data = enable && (fifo_usedw != '0);
  assign xfer      = uart_valid && uart_ready;
  assign word_done = (state == S_SEND) && xfer && (byte_idx == LAST_IDX);

`ifdef FRAME_HEADER_EN
  localparam int unsigned FC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  logic [FC_W-1:0] frame_cnt;

  assign hdr_due = (frame_cnt == '0);

  // Only a deliberate stop (enable low into idle) restarts the frame; an empty FIFO does not.
  always_ff @(posedge tx_spi_sclk_wire) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (next_state == S_IDLE && !enable) begin
      frame_cnt <= '0;
    end else if (word_done) begin
      frame_cnt <= (frame_cnt == FC_W'(FRAME_WORDS - 1)) ? '0 : frame_cnt + 1'b1;
    end
  end
`else
  assign hdr_due = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (have_data) next_state = hdr_due ? S_HDR : S_POP;
      S_HDR:   if (xfer) next_state = S_POP;
      S_POP:   next_state = S_WAIT;
      S_WAIT:  if (lat_cnt == LAT_LAST) next_state = S_SEND;
      S_SEND:  if (word_done) next_state = S_NEXT;
      S_NEXT:  next_state = have_data ? (hdr_due ? S_HDR : S_POP) : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_spi_sclk_wire) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_idx <= '0;
      lat_cnt  <= '0;
      word     <= '0;
      sent     <= '0;
    end else begin
      state <= next_state;
      case (state)
        S_POP: lat_cnt <= '0;
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            word     <= fifo_q;
            byte_idx <= '0;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_SEND: begin
          if (xfer) begin
            if (byte_idx == LAST_IDX) begin
              byte_idx <= '0;
              if (sent != '1) sent <= sent + 12'd1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  word_byte_sel #(
    .DATA_W (DATA_W)
  ) u_byte_sel (
    .word     (word),
    .idx      (byte_idx),
    .byte_out (sel_byte)
  );

  always_comb begin
    uart_byte = '0;
    if (state == S_SEND)     uart_byte = sel_byte;
    else if (state == S_HDR) uart_byte = HDR_BYTE;
  end

  assign fifo_rdreq   = (state == S_POP);
  assign uart_valid   = (state == S_SEND) || (state == S_HDR);
  assign uart_counter = (state == S_HDR) ? 2'd3 : byte_idx;
  assign busy         = (state != S_IDLE);
  assign words_sent   = sent;

endmodule
